// File: rtl/gb_dma_pkg.sv
// Shared constants for the Game Boy DMA controller: register map, FSM states,
// destination modes and the echo-RAM page remap.
package gb_dma_pkg;

    localparam logic [2:0] REG_OAMPG = 3'd0;
    localparam logic [2:0] REG_SRCH  = 3'd1;
    localparam logic [2:0] REG_SRCL  = 3'd2;
    localparam logic [2:0] REG_DSTH  = 3'd3;
    localparam logic [2:0] REG_DSTL  = 3'd4;
    localparam logic [2:0] REG_CTRL  = 3'd5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam logic MODE_OAM   = 1'b0;
    localparam logic MODE_BLOCK = 1'b1;

    // Byte index width: covers the 2048-byte maximum block transfer.
    localparam int IDX_W = 12;

    function automatic logic [7:0] echo_page(input logic [7:0] page, input logic mirror);
        return (mirror && page[7:5] == 3'b111) ? page - 8'h20 : page;
    endfunction

endpackage

// File: rtl/gb_dma_slot_timer.sv
// Tick counter for one byte slot; raises 'last' on the final tick of each slot.
module gb_dma_slot_timer #(
    parameter int STEP_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic last
);

    localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    logic [TW-1:0] tick;

    assign last = run && (tick == TW'(STEP_TICKS - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || !run || last) begin
            tick <= '0;
        end else begin
            tick <= tick + 1'b1;
        end
    end

endmodule

// File: rtl/gb_dma_ctrl.sv
// DMA engine: DMG-style OAM copy from FF46 and CGB-style block copy, one byte
// per slot with a one-slot read/write pipeline (read slot k, write slot k+1).
module gb_dma_ctrl
    import gb_dma_pkg::*;
#(
    parameter int   OAM_LEN     = 160,
    parameter int   STEP_TICKS  = 4,
    parameter int   DST_WIDTH   = 13,
    parameter logic MIRROR_ECHO = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           reg_adr,
    input  logic [7:0]           reg_din,
    input  logic                 reg_write,
    output logic [7:0]           reg_dout,
    output logic [15:0]          adr_rd,
    output logic                 rd,
    input  logic [7:0]           din,
    output logic [DST_WIDTH-1:0] adr_wr,
    output logic                 wr,
    output logic [7:0]           dout,
    output logic                 active,
    output logic                 mode,
    output logic [1:0]           dbg_state
);

    logic [1:0]           state;
    logic [7:0]           oampg, srch, srcl, dsth, dstl;
    logic [15:0]          base;
    logic [DST_WIDTH-1:0] dst;
    logic [IDX_W-1:0]     len_m1, idx;
    logic [6:0]           nblk_m1;
    logic [7:0]           buf_q;
    logic                 mode_q;
    logic                 slot_last, oam_start, blk_start, finishing;
    logic                 rd_en, wr_en;
    logic [7:0]           ctrl_rd, rd_mux;
    logic [15:0]          dst_cfg;

    gb_dma_slot_timer #(.STEP_TICKS(STEP_TICKS)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (oam_start || blk_start),
        .run   (active),
        .last  (slot_last)
    );

    assign active    = (state != ST_IDLE);
    assign mode      = mode_q;
    assign dbg_state = state;
    assign dst_cfg   = {dsth, dstl[7:4], 4'h0};

    // An OAM start always wins (abort/restart); a block start is only taken
    // when idle or on the very last clock of the closing FLUSH slot.
    assign oam_start = reg_write && (reg_adr == REG_OAMPG);
    assign finishing = (state == ST_FLUSH) && slot_last;
    assign blk_start = reg_write && (reg_adr == REG_CTRL) && !reg_din[7] && (!active || finishing);

    assign rd_en = (state == ST_RUN) && !reset;
    assign wr_en = (((state == ST_RUN) && (idx != '0)) || (state == ST_FLUSH)) && !oam_start && !reset;

    assign rd     = rd_en;
    assign adr_rd = rd_en ? base + 16'(idx) : 16'h0000;
    assign wr     = wr_en;
    assign adr_wr = wr_en ? dst + DST_WIDTH'(idx - IDX_W'(1)) : '0;
    assign dout   = wr_en ? buf_q : 8'h00;

    always_comb begin
        ctrl_rd = 8'hFF;
        if (active && mode_q == MODE_BLOCK) begin
            ctrl_rd = {1'b0, (state == ST_FLUSH) ? 7'd0 : nblk_m1 - idx[10:4]};
        end
    end

    always_comb begin
        rd_mux = 8'hFF;
        case (reg_adr)
            REG_OAMPG: rd_mux = oampg;
            REG_SRCH:  rd_mux = srch;
            REG_SRCL:  rd_mux = srcl;
            REG_DSTH:  rd_mux = dsth;
            REG_DSTL:  rd_mux = dstl;
            REG_CTRL:  rd_mux = ctrl_rd;
            default:   rd_mux = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            oampg    <= 8'h00;
            srch     <= 8'h00;
            srcl     <= 8'h00;
            dsth     <= 8'h00;
            dstl     <= 8'h00;
            base     <= 16'h0000;
            dst      <= '0;
            len_m1   <= '0;
            nblk_m1  <= 7'd0;
            idx      <= '0;
            buf_q    <= 8'h00;
            mode_q   <= MODE_OAM;
            reg_dout <= 8'hFF;
        end else begin
            reg_dout <= rd_mux;
            if (reg_write) begin
                case (reg_adr)
                    REG_OAMPG: oampg <= reg_din;
                    REG_SRCH:  srch  <= reg_din;
                    REG_SRCL:  srcl  <= reg_din;
                    REG_DSTH:  dsth  <= reg_din;
                    REG_DSTL:  dstl  <= reg_din;
                    default:   ;
                endcase
            end
            if (oam_start) begin
                state  <= ST_DELAY;
                idx    <= '0;
                base   <= {echo_page(reg_din, MIRROR_ECHO), 8'h00};
                dst    <= '0;
                len_m1 <= IDX_W'(OAM_LEN - 1);
                mode_q <= MODE_OAM;
            end else if (blk_start) begin
                state   <= ST_DELAY;
                idx     <= '0;
                base    <= {srch, srcl[7:4], 4'h0};
                dst     <= dst_cfg[DST_WIDTH-1:0];
                len_m1  <= {1'b0, reg_din[6:0], 4'hF};
                nblk_m1 <= reg_din[6:0];
                mode_q  <= MODE_BLOCK;
            end else if (slot_last) begin
                case (state)
                    ST_DELAY: state <= ST_RUN;
                    ST_RUN: begin
                        buf_q <= din;
                        idx   <= idx + IDX_W'(1);
                        if (idx == len_m1) state <= ST_FLUSH;
                    end
                    ST_FLUSH: state <= ST_IDLE;
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gb_dma_ctrl.sv
// Bench for gb_dma_ctrl: random source memory, expected destination writes
// queued from a byte-level copy model and popped by a negedge write monitor.
module tb_gb_dma_ctrl;
    import gb_dma_pkg::*;

    localparam int OAM_LEN = 160;
    localparam int STEP    = 4;
    localparam int DW      = 13;
    localparam int CLK_P   = 10;

    logic          clk, reset, reg_write, rd, wr, active, mode;
    logic [2:0]    reg_adr;
    logic [7:0]    reg_din, reg_dout, din, dout;
    logic [15:0]   adr_rd;
    logic [DW-1:0] adr_wr;
    logic [1:0]    dbg_state;

    logic [7:0]  mem [0:65535];
    logic [21:0] exp_q[$];
    logic [21:0] mon_exp;
    logic        prev_wr = 1'b0;
    logic [DW-1:0] prev_adr = '0;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    gb_dma_ctrl #(
        .OAM_LEN(OAM_LEN), .STEP_TICKS(STEP), .DST_WIDTH(DW), .MIRROR_ECHO(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .reg_adr(reg_adr), .reg_din(reg_din),
        .reg_write(reg_write), .reg_dout(reg_dout), .adr_rd(adr_rd), .rd(rd),
        .din(din), .adr_wr(adr_wr), .wr(wr), .dout(dout), .active(active),
        .mode(mode), .dbg_state(dbg_state)
    );

    assign din = mem[adr_rd];

    initial begin
        clk = 1'b0;
        forever #(CLK_P / 2) clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // All driver tasks start and end at posedge+1.
    task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
        reg_adr = a; reg_din = d; reg_write = 1'b1;
        @(posedge clk); #1;
        reg_write = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
        reg_adr = a;
        @(posedge clk); #1;
        d = reg_dout;
    endtask

    task automatic wait_rd(input logic [15:0] a, input string name);
        int n = 0;
        while (!(rd && adr_rd == a) && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        if (!(rd && adr_rd == a)) begin
            n_checks++; n_fail++;
            $display("FAIL %s: read of %0h never seen", name, a);
        end
    endtask

    task automatic wait_idle(input time t0, input int exp_cycles, input string name);
        int n = 0;
        while (active && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        if (active) begin
            n_checks++; n_fail++;
            $display("FAIL %s: transfer still active after %0d cycles", name, n);
        end else begin
            check(name, int'(($time - t0) / CLK_P), exp_cycles);
        end
    endtask

    task automatic check_drained(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] oam_src(input logic [7:0] page, input int i);
        int p;
        p = page;
        if (p >= 'hE0) p = p - 'h20;
        return 16'(p * 256 + i);
    endfunction

    task automatic push_oam(input logic [7:0] page, input int nbytes);
        for (int i = 0; i < nbytes; i++)
            exp_q.push_back({MODE_OAM, 13'(i), mem[oam_src(page, i)]});
    endtask

    task automatic push_blk(input logic [15:0] src, input logic [15:0] dst, input int nblk);
        logic [15:0] b, a;
        logic [DW-1:0] w;
        b = {src[15:4], 4'h0};
        for (int i = 0; i < nblk * 16; i++) begin
            a = b + 16'(i);
            w = 13'({dst[15:4], 4'h0}) + 13'(i);
            exp_q.push_back({MODE_BLOCK, w, mem[a]});
        end
    endtask

    task automatic setup_blk(input logic [15:0] src, input logic [15:0] dst);
        reg_wr(REG_SRCH, src[15:8]);
        reg_wr(REG_SRCL, src[7:0]);
        reg_wr(REG_DSTH, dst[15:8]);
        reg_wr(REG_DSTL, dst[7:0]);
    endtask

    // Write monitor: one event per destination byte (wr rising or address change).
    always @(negedge clk) begin
        if (mon_en) begin
            check("strobe_while_idle", {31'd0, (rd || wr) && !active}, 0);
            if (wr && (!prev_wr || adr_wr != prev_adr)) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL write_unexpected: adr %0h data %0h, none expected", adr_wr, dout);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("write", {10'd0, mode, adr_wr, dout}, {10'd0, mon_exp});
                end
            end
        end
        prev_wr  = wr;
        prev_adr = adr_wr;
    end

    initial begin
        logic [7:0]  rv;
        logic [15:0] src, dst;
        time         t0;
        int          nb;

        reset = 1'b1; reg_write = 1'b0; reg_adr = 3'd0; reg_din = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("reset_active", active, 0);
        check("reset_rd", rd, 0);
        check("reset_wr", wr, 0);
        check("reset_mode", mode, 0);
        check("reset_reg_dout", reg_dout, 8'hFF);
        reset = 1'b0;
        mon_en = 1'b1;

        // OAM transfer from page C1: timing of first read and of completion
        push_oam(8'hC1, OAM_LEN);
        reg_wr(REG_OAMPG, 8'hC1);
        t0 = $time;
        check("oam_active_rise", active, 1);
        repeat (3) begin @(posedge clk); #1; end
        check("oam_delay_no_rd", rd, 0);
        @(posedge clk); #1;
        check("oam_first_rd", {15'd0, rd, adr_rd}, {15'd0, 1'b1, 16'hC100});
        wait_idle(t0, (OAM_LEN + 2) * STEP, "oam_duration");
        check_drained("oam_drained");

        // Echo page remap and OAMPG readback
        push_oam(8'hFE, OAM_LEN);
        reg_wr(REG_OAMPG, 8'hFE);
        t0 = $time;
        repeat (4) begin @(posedge clk); #1; end
        check("echo_first_rd", adr_rd, 16'hDE00);
        wait_idle(t0, (OAM_LEN + 2) * STEP, "echo_duration");
        reg_rd(REG_OAMPG, rv);
        check("oampg_readback", rv, 8'hFE);
        check_drained("echo_drained");

        // Restart with a new page at byte 50: slots 1..49 wrote bytes 0..48
        push_oam(8'hC1, 49);
        reg_wr(REG_OAMPG, 8'hC1);
        wait_rd(16'hC100 + 16'd50, "abort_reach");
        push_oam(8'hC2, OAM_LEN);
        reg_adr = REG_OAMPG; reg_din = 8'hC2; reg_write = 1'b1;
        #1;
        check("abort_no_wr", wr, 0);
        @(posedge clk); #1;
        reg_write = 1'b0;
        t0 = $time;
        check("abort_active_held", active, 1);
        repeat (3) begin @(posedge clk); #1; end
        check("abort_delay_no_rd", rd, 0);
        @(posedge clk); #1;
        check("abort_restart_rd", {15'd0, rd, adr_rd}, {15'd0, 1'b1, 16'hC200});
        wait_idle(t0, (OAM_LEN + 2) * STEP, "abort_duration");
        check_drained("abort_drained");

        // Block copy with low nibbles forced to zero
        setup_blk(16'hC01F, 16'h8105);
        push_blk(16'hC01F, 16'h8105, 2);
        reg_wr(REG_CTRL, 8'h01);
        t0 = $time;
        reg_rd(REG_CTRL, rv);
        check("ctrl_rd_start", rv, 8'h01);
        wait_rd(16'hC010 + 16'd20, "blk_reach");
        reg_rd(REG_CTRL, rv);
        check("ctrl_rd_mid", rv, 8'h00);
        wait_idle(t0, (32 + 2) * STEP, "blk_duration");
        reg_rd(REG_CTRL, rv);
        check("ctrl_rd_done", rv, 8'hFF);
        check_drained("blk_drained");

        // Destination wrap at 2^13, CTRL write while active ignored
        src = 16'($urandom);
        setup_blk(src, 16'h1FF0);
        push_blk(src, 16'h1FF0, 2);
        reg_wr(REG_CTRL, 8'h01);
        t0 = $time;
        wait_rd({src[15:4], 4'h0} + 16'd10, "wrap_reach");
        reg_wr(REG_CTRL, 8'h05);
        wait_idle(t0, (32 + 2) * STEP, "wrap_duration");
        check_drained("wrap_drained");

        // Randomized mix of OAM and block transfers
        for (int t = 0; t < 6; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                rv = 8'($urandom_range(0, 255));
                push_oam(rv, OAM_LEN);
                reg_wr(REG_OAMPG, rv);
                t0 = $time;
                wait_idle(t0, (OAM_LEN + 2) * STEP, "rand_oam_duration");
            end else begin
                src = 16'($urandom);
                dst = 16'($urandom);
                nb  = $urandom_range(1, 4);
                setup_blk(src, dst);
                push_blk(src, dst, nb);
                reg_wr(REG_CTRL, 8'(nb - 1));
                t0 = $time;
                wait_idle(t0, (nb * 16 + 2) * STEP, "rand_blk_duration");
            end
            check_drained("rand_drained");
        end

        // Reset at byte 10: slots 1..9 wrote bytes 0..8, nothing afterwards
        reg_wr(REG_SRCH, 8'h5A);
        push_oam(8'hC3, 9);
        reg_wr(REG_OAMPG, 8'hC3);
        wait_rd(16'hC300 + 16'd10, "rst_reach");
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_active", active, 0);
        check("rst_wr", wr, 0);
        check("rst_rd", rd, 0);
        check("rst_reg_dout", reg_dout, 8'hFF);
        reset = 1'b0;
        for (int r = 0; r < 8; r++) begin
            reg_rd(3'(r), rv);
            check("rst_reg_read", rv, (r < 5) ? 8'h00 : 8'hFF);
        end
        repeat (50) @(posedge clk);
        #1;
        check_drained("rst_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gb_dma_ctrl.md
Name: gb_dma_ctrl

Overview:
- Parametrised DMA engine that replaces the tied-off `dma_active` path in the Game Boy top level.
- Drives the existing `adr_dma_rd`, `rd_dma`, `adr_dma_wr`, `wr_dma` and `data_dma_out` nets, plus `dma_active`.
- Two modes:
  - OAM mode: DMG FF46 behaviour, fixed length.
  - Block mode: CGB-style general copy; 16-bit source, DST_WIDTH destination, length in 16-byte blocks.
- Registers sit behind one CPU chip-select from gb_iomap.

Parameters:
- OAM_LEN, 160: bytes copied per OAM transfer.
- STEP_TICKS, 4: clocks per byte slot (one M-cycle); must be ≥ 2.
- DST_WIDTH, 13: width of destination address (OAM uses the low 8 bits).
- MIRROR_ECHO, 1: if 1, source pages 0xE0–0xFF map to page − 0x20.

Ports:
- clk  in  1  system clock (gbclk)
- reset  in  1  synchronous, active-high reset
- reg_adr  in  3  register select
- reg_din  in  8  CPU write data
- reg_write  in  1  CPU write strobe, already qualified by chip-select
- reg_dout  out  8  register read data
- adr_rd  out  16  source address
- rd  out  1  source read strobe
- din  in  8  source data (data_dma_in)
- adr_wr  out  DST_WIDTH  destination address
- wr  out  1  destination write strobe
- dout  out  8  destination write data
- active  out  1  transfer in progress; top uses it for CPU lockout
- mode  out  1  0 = OAM destination, 1 = block (VRAM) destination

Behaviour:
- Registers:
  - 0 OAMPG: write starts an OAM transfer; read returns the last value written.
  - 1 SRCH, 2 SRCL: source address. SRCL[3:0] is forced 0 on use.
  - 3 DSTH, 4 DSTL: destination address, truncated to DST_WIDTH. DSTL[3:0] is forced 0.
  - 5 CTRL:
    - Write with bit7 = 0 starts a block transfer of (din[6:0]+1)*16 bytes.
    - Write with bit7 = 1 is ignored.
    - Read returns {!active_block, remaining_blocks−1}; reads 0xFF when idle.
  - Registers 6–7 read 0xFF; writes to them are ignored.
- Reset: every output is 0 except reg_dout = 0xFF. All registers clear to 0x00; state = IDLE.
- Slot counter: counts 0..STEP_TICKS−1 and wraps; a byte index increments at each wrap.
- FSM: IDLE → DELAY → RUN → FLUSH → IDLE.
  - DELAY lasts one slot; active = 1 from the first DELAY clock.
  - RUN slot k:
    - rd = 1 for the whole slot; adr_rd = base + k.
    - din is latched into the buffer on the last tick of the slot.
    - wr = 1 for slots k ≥ 1, with adr_wr = dst + k − 1 and dout = buffer.
  - FLUSH: one extra slot that performs only the final write; rd = 0.
  - Total transfer time = (LEN+2)*STEP_TICKS clocks. active drops on the clock after the FLUSH slot ends.
- OAM mode:
  - base = {page, 8'h00}, with the MIRROR_ECHO remap if enabled; dst = 0; LEN = OAM_LEN; mode = 0.
- Block mode:
  - base = {SRCH, SRCL & F0}; dst = {DSTH, DSTL & F0} truncated to DST_WIDTH; mode = 1.
  - Destination address wraps modulo 2^DST_WIDTH. Source address wraps modulo 2^16.
- Restart rules:
  - A write to OAMPG while active aborts the current transfer: no write in the current slot, next state DELAY, index = 0, active stays 1.
  - A CTRL start while active is ignored.
- Simultaneous events:
  - reset wins over everything.
  - A reg write landing on the final FLUSH clock is treated as a new start; active stays high with no gap.
- A reset mid-transfer clears everything within one clock. No partial write occurs after reset is asserted.

Decomposition:
- Shared package gb_dma_pkg:
  - register offset constants REG_OAMPG..REG_CTRL;
  - FSM state enum;
  - MODE_OAM / MODE_BLOCK.
- One natural sub-module, gb_dma_slot_timer: slot tick counter plus last-tick pulse, parametrised by STEP_TICKS.
- Address generation and the FSM stay in gb_dma_ctrl.

Test Plan:
- Write OAMPG = 0xC1 after reset → active rises next clk.
  - First rd at adr 0xC100 after 4 clocks.
  - wr to adr_wr 0x00 with the byte from 0xC100 in the following slot.
  - Last wr to 0x9F.
  - active low exactly 648 clocks after the write.
- OAMPG = 0xFE with MIRROR_ECHO = 1 → reads start at 0xDE00. Readback of reg 0 = 0xFE.
- Rewrite OAMPG = 0xC2 at byte 50 → no wr in that slot; after one DELAY slot, reads restart at 0xC200 with dst 0x00; active never drops.
- SRC = 0xC01F, DST = 0x8105, CTRL = 0x01 → copies 32 bytes 0xC010..0xC02F to 0x0100..0x011F with mode = 1.
  - CTRL reads 0x01, then 0x00, then 0xFF when done.
- DST = 0x1FF0, CTRL = 0x01 (DST_WIDTH = 13) → destination wraps from 0x1FFF to 0x0000; a CTRL write mid-transfer is ignored.
- Assert reset at byte 10 → next clk: active = 0, wr = 0, rd = 0, all registers read 0x00 / 0xFF; no further strobes.
